// File: rtl/multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// encodings and the default operand width.
package multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/adder_ripple_nbit.sv
// WIDTH-bit ripple-carry adder built from a chain of 1-bit full adders;
// the final carry is exposed so the caller can keep the overflow bit.
module adder_ripple_nbit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    logic [WIDTH:0] w_c;

    assign w_c[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
            assign sum[gi]    = a[gi] ^ b[gi] ^ w_c[gi];
            assign w_c[gi+1]  = (a[gi] & b[gi]) | (w_c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign carry = w_c[WIDTH];

endmodule

// File: rtl/multiplier_seq.sv
// Sequential shift-add multiplier, one iteration per clock, fixed latency.
// Define MULTIPLIER_SEQ_SIGNED_EN for two's-complement operands and result.
module multiplier_seq
    import multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_result;

    logic [WIDTH-1:0]   w_mcand_in;
    logic [WIDTH-1:0]   w_mplier_in;
    logic [WIDTH-1:0]   w_add_b;
    logic [WIDTH-1:0]   w_sum;
    logic               w_carry;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_prod_final;
    logic               w_accept;
    logic               w_last;

`ifdef MULTIPLIER_SEQ_SIGNED_EN
    logic r_neg;

    // Magnitudes fit in WIDTH unsigned bits, including the most negative value.
    assign w_mcand_in   = multiplicand[WIDTH-1] ? (~multiplicand) + WIDTH'(1) : multiplicand;
    assign w_mplier_in  = multiplier[WIDTH-1]   ? (~multiplier) + WIDTH'(1)   : multiplier;
    assign w_prod_final = r_neg ? (~w_acc_next) + (2*WIDTH)'(1) : w_acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg <= 1'b0;
        end else if (w_accept) begin
            r_neg <= multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
        end
    end
`else
    assign w_mcand_in   = multiplicand;
    assign w_mplier_in  = multiplier;
    assign w_prod_final = w_acc_next;
`endif

    assign w_accept = (r_state != BUSY) && start;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    // Only add when the current multiplier bit (acc LSB) is set.
    assign w_add_b = r_acc[0] ? r_mcand : '0;

    adder_ripple_nbit #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a     (r_acc[2*WIDTH-1:WIDTH]),
        .b     (w_add_b),
        .sum   (w_sum),
        .carry (w_carry)
    );

    // {carry, upper sum, lower half} shifted right by one.
    assign w_acc_next = {w_carry, w_sum, r_acc[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = BUSY;
            BUSY:    if (w_last) w_state_next = DONE;
            DONE:    w_state_next = start ? BUSY : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_mcand <= w_mcand_in;
            r_acc   <= {{WIDTH{1'b0}}, w_mplier_in};
            r_cnt   <= '0;
        end else if (r_state == BUSY) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_result <= w_prod_final;
            end
        end
    end

    assign busy   = (r_state == BUSY);
    assign ready  = ~busy;
    assign done   = (r_state == DONE);
    assign result = r_result;

endmodule

// File: tb/tb_multiplier_seq.sv
// Directed-vector bench for multiplier_seq at WIDTH=4; the signed vectors
// are selected when MULTIPLIER_SEQ_SIGNED_EN is defined.
module tb_multiplier_seq;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] multiplicand;
    logic [W-1:0] multiplier;
    logic         ready;
    logic         busy;
    logic         done;
    logic [2*W-1:0] result;

    int n_checks;
    int n_errors;

    multiplier_seq #(
        .WIDTH (W),
        .CNT_W (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .ready        (ready),
        .busy         (busy),
        .done         (done),
        .result       (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for done, returning the number of edges elapsed (bounded).
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    // Accept one operation, check latency, product and post-done state.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp);
        int cyc;
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        tick();
        start = 1'b0;
        check_val({tag, " busy after accept"}, 32'(busy), 32'd1);
        wait_done(cyc);
        check_val({tag, " latency"}, 32'(cyc), 32'd4);
        check_val({tag, " result"}, 32'(result), 32'(exp));
        check_val({tag, " ready with done"}, 32'(ready), 32'd1);
        tick();
        check_val({tag, " done single pulse"}, 32'(done), 32'd0);
        check_val({tag, " idle not busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc;
        int pulses;
        n_checks     = 0;
        n_errors     = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        #12;
        check_val("reset ready", 32'(ready), 32'd1);
        check_val("reset busy", 32'(busy), 32'd0);
        check_val("reset done", 32'(done), 32'd0);
        check_val("reset result", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

`ifdef MULTIPLIER_SEQ_SIGNED_EN
        run_op("-8x7", 4'h8, 4'h7, 8'hC8);
        run_op("-8x-8", 4'h8, 4'h8, 8'h40);
        run_op("3x-2", 4'h3, 4'hE, 8'hFA);
        run_op("-1x-1", 4'hF, 4'hF, 8'h01);
`else
        run_op("15x15", 4'd15, 4'd15, 8'd225);
        run_op("0x9", 4'd0, 4'd9, 8'd0);
        run_op("1x13", 4'd1, 4'd13, 8'd13);
        run_op("12x10", 4'd12, 4'd10, 8'd120);

        // start and operand changes while busy are ignored
        start = 1'b1; multiplicand = 4'd6; multiplier = 4'd7;
        tick();
        multiplicand = 4'd2; multiplier = 4'd2;
        tick();
        tick();
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                pulses++;
                check_val("6x7 result", 32'(result), 32'd42);
            end
            tick();
        end
        check_val("6x7 done pulses", 32'(pulses), 32'd1);

        // back-to-back with start held high
        start = 1'b1; multiplicand = 4'd3; multiplier = 4'd5;
        tick();
        multiplicand = 4'd4; multiplier = 4'd4;
        wait_done(cyc);
        check_val("b2b first latency", 32'(cyc), 32'd4);
        check_val("b2b first result", 32'(result), 32'd15);
        tick();
        start = 1'b0;
        check_val("b2b restart busy", 32'(busy), 32'd1);
        wait_done(cyc);
        check_val("b2b pulse spacing", 32'(cyc + 1), 32'd5);
        check_val("b2b second result", 32'(result), 32'd16);
        tick();

        // reset during iteration 2 abandons the computation
        start = 1'b1; multiplicand = 4'd9; multiplier = 4'd9;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_val("midreset busy", 32'(busy), 32'd0);
        check_val("midreset ready", 32'(ready), 32'd1);
        check_val("midreset done", 32'(done), 32'd0);
        check_val("midreset result", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) pulses++;
        end
        check_val("midreset no done", 32'(pulses), 32'd0);
        run_op("2x3", 4'd2, 4'd3, 8'd6);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multiplier_seq.md
MULTIPLIER_SEQ -- requirements
Module: multiplier_seq

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits, legal range 2..32.
REQ-002 Parameter CNT_W, default 5: iteration counter width; SHALL satisfy 2**CNT_W > WIDTH.
REQ-003 Port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port start  input  1  request; sampled only while ready=1.
REQ-006 Port multiplicand  input  WIDTH  first operand; captured on the accepting edge.
REQ-007 Port multiplier  input  WIDTH  second operand; captured on the accepting edge.
REQ-008 Port ready  output  1  high in IDLE or DONE; a new start is accepted.
REQ-009 Port busy  output  1  high while iterating.
REQ-010 Port done  output  1  one-cycle pulse: product just became valid.
REQ-011 Port result  output  2*WIDTH  product; holds its value until the next accepted start.

Function
REQ-012 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-013 IDLE: start=1 at an edge -> latch operands, clear accumulator, counter=0, go to BUSY.
REQ-014 BUSY: shift-add each cycle; if the multiplier LSB=1, add the multiplicand into the upper accumulator half. Shift the {carry, accumulator} right by 1 and increment the counter.
REQ-015 BUSY: after the WIDTH-th iteration edge -> go to DONE and load result from the accumulator.
REQ-016 Latency SHALL be fixed: start accepted at edge k -> done=1 in the cycle following edge k+WIDTH. Latency is independent of operand values.
REQ-017 DONE SHALL last exactly one cycle. start=1 in DONE is accepted and the FSM goes to BUSY; otherwise it goes to IDLE.
REQ-018 start while BUSY SHALL be ignored. Operand changes while BUSY SHALL have no effect.
REQ-019 The adder carry SHALL be retained so that no overflow occurs. The unsigned product of WIDTH x WIDTH SHALL be exact in 2*WIDTH bits.
REQ-020 busy, ready and done SHALL be mutually consistent: ready = ~busy, and done implies ready.
REQ-021 result SHALL be updated only on the BUSY->DONE edge.

Reset
REQ-022 rst_n=0 SHALL immediately force IDLE, result=0, done=0, busy=0, ready=1, counter=0, without waiting for a clock edge.
REQ-023 Reset mid-operation SHALL abandon the computation; no done pulse for it SHALL ever appear.
REQ-024 Deassertion SHALL be synchronised externally; the first edge after release may accept start.

Configuration
REQ-025 Macro MULTIPLIER_SEQ_SIGNED_EN: when defined, operands and result are two's complement.
REQ-026 With the macro defined, operand magnitudes are taken at the accept edge and the unsigned core runs unchanged. The result is negated on the BUSY->DONE edge if the operand signs differ, and the latency is unchanged.
REQ-027 Without the macro, all values are unsigned and no sign logic is synthesised.

Structure
REQ-028 The shared package (multiplier_pkg) SHALL hold the state encodings IDLE=2'b00, BUSY=2'b01 and DONE=2'b10, plus the default WIDTH constant.
REQ-029 The WIDTH-bit add SHALL be a separate sub-module, adder_ripple_nbit (parameter WIDTH, outputs sum and carry), built from 1-bit full adders.
REQ-030 No other sub-modules.

Verification (WIDTH=4 unless stated)
REQ-031 Reset, then start with 15 and 15 -> done one cycle after edge k+4, result=225, busy low afterwards.
REQ-032 Operands 0 and 9, and operands 1 and 13 -> results 0 and 13, with latency identical to REQ-031.
REQ-033 start with 6 and 7, then start=1 with operands 2 and 2 during BUSY -> result=42 and a single done pulse.
REQ-034 Back-to-back: start held high with operands 3x5 then 4x4 -> two done pulses 5 cycles apart, results 15 then 16.
REQ-035 rst_n low at iteration 2 of 9x9 -> outputs reset immediately and no done pulse appears; a subsequent 2x3 gives result=6.
REQ-036 With MULTIPLIER_SEQ_SIGNED_EN defined: -8 x 7 -> -56 (8'hC8), and -8 x -8 -> 64 (8'h40).
